phase_wave_gen: RTL
===================

// Module: phase_wave_gen
// PURPOSE
//  Neuron oscillator output stage: drives a 50%-duty square wave nout whose phase is set by a
//  PHASE_BITS-wide phase register, in steps of DIV clocks.
//  Feeds the wave-arrival comparator. Takes that comparator's lead/lag verdict back on upd/lead.
//  Each verdict moves the output phase one step toward the reference wave nin.
//  Provides a rise pulse so the controller can re-arm the comparator once per output period.
// PARAMETERS
//  PHASE_BITS  4  phase resolution; N = 2**PHASE_BITS steps per period
//  DIV         2  clocks per phase step (>=1); period = N*DIV clocks
// PORTS
//  clk         in   1           system clock, all logic on posedge
//  re          in   1           synchronous reset, active-high
//  en          in   1           run enable; 0 freezes prescaler/step counter and holds nout=0
//  sync        in   1           1-cycle pulse: realign prescaler and step counter to 0
//  load        in   1           1-cycle pulse: phase <= phase_init
//  phase_init  in   PHASE_BITS  initial phase value for load
//  upd         in   1           1-cycle pulse: apply comparator verdict
//  lead        in   1           verdict, valid with upd: 1 = nin rose first (advance), 0 = retard
//  nout        out  1           oscillator output wave (registered)
//  rise        out  1           1-cycle pulse in the cycle nout goes 0->1
//  phase_o     out  PHASE_BITS  current phase register
// BEHAVIOUR
//  Reset (re=1 at posedge): pre=0, cnt=0, phase=0, nout=0, rise=0. re overrides all other inputs.
//  Prescaler pre in 0..DIV-1 and step counter cnt (PHASE_BITS bits) advance only when en=1.
//  - pre==DIV-1: pre<=0, cnt<=cnt+1, cnt wraps N-1 -> 0 (mod N).
//  - otherwise: pre<=pre+1.
//  sync=1: pre<=0, cnt<=0 that cycle, regardless of en. sync has priority over counting.
//  pos = (cnt + phase) mod N, combinational from current registers, PHASE_BITS wide.
//  nout <= en ? ~pos[PHASE_BITS-1] : 0.
//  - One-cycle latency from register change to nout.
//  - Output is high for pos in 0..N/2-1.
//  rise <= en & ~pos[PHASE_BITS-1] & ~nout. Registered with nout; high exactly when nout goes 0->1.
//  Phase register update priority, per cycle:
//  - 1. load: phase <= phase_init.
//  - 2. upd & lead: phase <= phase+1 mod N. Output advances DIV clocks.
//  - 3. upd & ~lead: phase <= phase-1 mod N. Output retards DIV clocks.
//  - 4. Otherwise hold.
//  Phase wrap-around is modular: N-1+1 -> 0 and 0-1 -> N-1. No saturation.
//  load and upd in the same cycle: load wins and upd is dropped.
//  Phase updates are legal in any cycle, including with en=0.
//  - The new phase affects nout from the next cycle.
//  - A phase step can shorten or lengthen the current half-period by DIV clocks. No glitch shorter than 1 clock.
//  en deassert mid-period: counters freeze, nout=0 next cycle, no rise.
//  en reassert: counting resumes from the frozen pre/cnt.
//  re mid-operation: all state cleared next cycle. phase_init is not reloaded; phase returns to 0.
//  phase_o = phase register, zero latency.
// TESTING
//  T1 reset, DIV=2, PHASE_BITS=4, en=1:
//   - nout=1 from cycle 1 for 16 clocks, then 0 for 16 clocks (period 32).
//   - rise at cycles 1, 33, 65.
//  T2 load phase_init=4 at cnt=0:
//   - nout falls 8 clocks earlier than in T1 (cnt=4 instead of 8).
//   - phase_o=4 the cycle after load.
//  T3 phase wrap:
//   - phase=15, upd with lead=1 -> phase_o=0.
//   - Then upd with lead=0 -> phase_o=15.
//   - nout edges shift by +/-2 clocks respectively.
//  T4 load with phase_init=7 and upd+lead=1 in the same cycle -> phase_o=7, not 8.
//  T5 sync mid-period at cnt=11 -> cnt=0, pre=0; nout=1 next cycle; rise pulses once.
//  T6 en=0 for 5 cycles mid-high, then en=1:
//   - nout=0 and no rise while disabled.
//   - Remaining high time resumes from the frozen count.
//   - re=1 during run -> all outputs 0, phase_o=0.

Source files
------------

// File: rtl/phase_wave_gen_if.sv
// rtl/phase_wave_gen_if.sv - control/status bundle between controller and phase wave generator
interface phase_wave_gen_if #(
  parameter int PHASE_BITS = 4
);
  logic                  en;
  logic                  sync;
  logic                  load;
  logic [PHASE_BITS-1:0] phase_init;
  logic                  upd;
  logic                  lead;
  logic                  nout;
  logic                  rise;
  logic [PHASE_BITS-1:0] phase_o;

  modport master (
    output en, sync, load, phase_init, upd, lead,
    input  nout, rise, phase_o
  );

  modport slave (
    input  en, sync, load, phase_init, upd, lead,
    output nout, rise, phase_o
  );
endinterface

// File: rtl/phase_wave_gen.sv
// rtl/phase_wave_gen.sv - square-wave oscillator output stage with comparator-steered phase
module phase_wave_gen #(
  parameter int PHASE_BITS = 4,
  parameter int DIV        = 2
) (
  input logic             clk,
  input logic             re,
  phase_wave_gen_if.slave bus
);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0]      pre;
  logic [PHASE_BITS-1:0] cnt;
  logic [PHASE_BITS-1:0] phase;
  logic [PHASE_BITS-1:0] pos;
  logic                  nout_q;
  logic                  rise_q;
  logic                  high;

  // modular add: the carry out of the top bit is the wrap at N
  assign pos  = cnt + phase;
  assign high = ~pos[PHASE_BITS-1];

  always_ff @(posedge clk) begin
    if (re) begin
      pre <= '0;
      cnt <= '0;
    end else if (bus.sync) begin
      pre <= '0;
      cnt <= '0;
    end else if (bus.en) begin
      if (pre == PRE_LAST) begin
        pre <= '0;
        cnt <= cnt + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      phase <= '0;
    end else if (bus.load) begin
      phase <= bus.phase_init;
    end else if (bus.upd) begin
      phase <= bus.lead ? phase + 1'b1 : phase - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      nout_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      nout_q <= bus.en & high;
      rise_q <= bus.en & high & ~nout_q;
    end
  end

  assign bus.nout    = nout_q;
  assign bus.rise    = rise_q;
  assign bus.phase_o = phase;
endmodule
